button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Debounces the lock's pushbuttons using the divided 1 kHz clock as the sample strobe.
//   Sits directly downstream of the clock divider and upstream of the code-entry logic.
//   Outputs clean per-button levels plus single-cycle press/release pulses in the clk domain.
// PARAMETERS
//   N_BTN           4   number of independent button channels
//   STABLE_SAMPLES  20  consecutive agreeing samples needed to accept a change (20 ms at 1 kHz); legal 1..255
//   BTN_ACTIVE_LOW  1   1: raw input 0 = pressed; 0: raw input 1 = pressed
// PORTS
//   clk          in   1      50 MHz system clock; all state updates on its rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   sample_clk   in   1      divided clock from the divider (1 kHz, 50% duty); treated as data, never as a clock
//   btn_raw      in   N_BTN  raw asynchronous pushbutton pins
//   btn_level    out  N_BTN  debounced level, 1 = pressed (polarity normalised)
//   btn_press    out  N_BTN  1-clk pulse when btn_level rises
//   btn_release  out  N_BTN  1-clk pulse when btn_level falls
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (clk, reset_n).
// - Reset: btn_level=0, btn_press=0, btn_release=0. Clear all counters and synchronizer flops.
//   sample edge detector resets to 0.
// - Input sync: btn_raw and sample_clk each pass through 2 clk flops.
//   Apply BTN_ACTIVE_LOW inversion after synchronisation.
// - Tick: sample_tick=1 for exactly one clk when the synced sample_clk is 1 and its previous value was 0.
//   This gives one tick per sample_clk period, 3-4 clk after the raw edge.
// - Per channel, on a tick only: synced sample s compared with btn_level.
//     s==btn_level           -> cnt<=0
//     s!=btn_level, cnt<STABLE_SAMPLES-1 -> cnt<=cnt+1
//     s!=btn_level, cnt==STABLE_SAMPLES-1 -> btn_level<=s, cnt<=0, pulse
// - Pulses: btn_press/btn_release are registered and asserted in the same clk cycle that btn_level changes.
//   They are high for exactly 1 clk and low otherwise.
// - Without a tick, all counters and levels hold; a stopped sample_clk freezes outputs.
// - Any bounce (one disagreeing/agreeing sample) before the count completes restarts the count from 0.
// - Latency: a clean change is accepted on the STABLE_SAMPLES-th tick after it is first sampled.
// - STABLE_SAMPLES=1: accepted on the first differing tick.
// - Counter width = $clog2(STABLE_SAMPLES+1); the counter never wraps (it is capped by the compare).
// - Channels are fully independent; simultaneous pulses on several bits are legal.
// - Reset mid-count: count is lost. A button held through reset produces a press STABLE_SAMPLES ticks after release of reset.
// STRUCTURE
// - lock_pkg: N_BTN default, STABLE_SAMPLES default, BTN_ACTIVE_LOW default.
//   lock_pkg also holds the function clog2_const used for counter widths.
// - Top: synchronizers, sample-edge detector, polarity normalisation, and a generate loop over channels.
// - Sub-module debounce_channel (one bit):
//   - inputs clk, reset_n, tick, sample
//   - outputs level, press, release
//   - holds cnt + level.
// TESTING  (override STABLE_SAMPLES=4; sample_clk period 200 ns for speed)
// - Reset: hold reset_n=0 with btn_raw all 0 (pressed, active-low) -> outputs 0.
//   Release reset -> btn_level=4'b1111 and btn_press=4'b1111 for 1 clk on the 4th tick.
// - Clean press ch0: btn_raw[0] 1->0 and held -> btn_level[0] rises on the 4th tick with a 1-clk btn_press[0].
//   No btn_press[0] on later ticks.
// - Bounce: btn_raw[0] toggles 0,1,0,1 across ticks 1-3, then is stable 0 -> level rises only 4 ticks after the final transition.
//   No intermediate pulses.
// - Release: the held button returns to 1 -> btn_release[0] is a 1-clk pulse on the 4th tick and btn_level[0] goes to 0.
//   btn_press stays 0.
// - Simultaneous: ch1 and ch3 are pressed on the same clk -> btn_press=4'b1010 in a single cycle.
//   ch0/ch2 are unaffected.
// - Reset mid-count: pulse reset_n low after tick 2 of a press -> outputs and counts clear asynchronously.
//   The press is then accepted 4 ticks after reset deassertion.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared defaults and constant helpers for the lock's front-end blocks.
package lock_pkg;

   localparam int N_BTN_DEF          = 4;
   localparam int STABLE_SAMPLES_DEF = 20;
   localparam bit BTN_ACTIVE_LOW_DEF = 1'b1;

   // Ceiling log2 usable in parameter expressions; returns 0 for v <= 1.
   function automatic int clog2_const(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: accepts a level change after STABLE_SAMPLES consecutive
// disagreeing ticks and emits a one-clk press or release pulse with the change.
module debounce_channel
   import lock_pkg::*;
#(
   parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic i_tick,
   input  logic i_sample,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int               CNT_W    = clog2_const(STABLE_SAMPLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_release;

   // NOTE: all state here uses non-blocking assignments so every flop samples
   // pre-edge values; blocking writes would make r_level order-dependent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         if (i_tick) begin
            if (i_sample == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_level   <= i_sample;
               r_cnt     <= '0;
               r_press   <= i_sample;
               r_release <= ~i_sample;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: synchronises raw pins and the 1 kHz sample clock, derives
// a one-clk sample tick from its rising edge, and runs one debounce_channel per button.
module button_debouncer
   import lock_pkg::*;
#(
   parameter int N_BTN          = N_BTN_DEF,
   parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
   parameter bit BTN_ACTIVE_LOW = BTN_ACTIVE_LOW_DEF
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sample_clk,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   logic [N_BTN-1:0] r_btn_meta;
   logic [N_BTN-1:0] r_btn_sync;
   logic             r_smp_meta;
   logic             r_smp_sync;
   logic             r_smp_prev;
   logic             w_tick;
   logic [N_BTN-1:0] w_sample;

   // NOTE: synchronizer and edge flops are reset too, so a tick can never be
   // generated from stale pre-reset history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_btn_meta <= '0;
         r_btn_sync <= '0;
         r_smp_meta <= 1'b0;
         r_smp_sync <= 1'b0;
         r_smp_prev <= 1'b0;
      end else begin
         r_btn_meta <= btn_raw;
         r_btn_sync <= r_btn_meta;
         r_smp_meta <= sample_clk;
         r_smp_sync <= r_smp_meta;
         r_smp_prev <= r_smp_sync;
      end
   end

   assign w_tick   = r_smp_sync & ~r_smp_prev;
   assign w_sample = BTN_ACTIVE_LOW ? ~r_btn_sync : r_btn_sync;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      debounce_channel #(
         .STABLE_SAMPLES (STABLE_SAMPLES)
      ) u_channel (
         .clk       (clk),
         .reset_n   (reset_n),
         .i_tick    (w_tick),
         .i_sample  (w_sample[g]),
         .o_level   (btn_level[g]),
         .o_press   (btn_press[g]),
         .o_release (btn_release[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (STABLE_SAMPLES=4, 200 ns sample clock).
// Expected outputs come from a sample-window model evaluated once per sample period.
module tb_button_debouncer;

   localparam int N  = 4;
   localparam int SS = 4;
   localparam bit AL = 1'b1;

   logic         clk        = 1'b0;
   logic         reset_n    = 1'b0;
   logic         sample_clk = 1'b0;
   logic [N-1:0] btn_raw    = '0;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;

   button_debouncer #(
      .N_BTN          (N),
      .STABLE_SAMPLES (SS),
      .BTN_ACTIVE_LOW (AL)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_clk  (sample_clk),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #10 clk = ~clk;

   int n_total   = 0;
   int n_pass    = 0;
   int period_no = 0;

   logic [N-1:0] m_level;
   logic [N-1:0] m_press;
   logic [N-1:0] m_rel;
   bit           hist[N][$];

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s period=%0d observed=%b expected=%b", tag, period_no, obs, exp);
   endtask

   task automatic model_reset();
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int ch = 0; ch < N; ch++) hist[ch].delete();
   endtask

   // A change is accepted once the last SS samples since the previous change
   // all disagree with the current level.
   task automatic model_tick(input logic [N-1:0] raw);
      m_press = '0;
      m_rel   = '0;
      for (int ch = 0; ch < N; ch++) begin
         bit s;
         bit ok;
         s = AL ? ~raw[ch] : raw[ch];
         hist[ch].push_back(s);
         if (hist[ch].size() > SS) void'(hist[ch].pop_front());
         ok = (hist[ch].size() == SS);
         for (int k = 0; k < hist[ch].size(); k++)
            if (hist[ch][k] == m_level[ch]) ok = 1'b0;
         if (ok) begin
            m_level[ch] = s;
            if (s) m_press[ch] = 1'b1;
            else   m_rel[ch]   = 1'b1;
            hist[ch].delete();
         end
      end
   endtask

   // One 10-clk sample period starting on a falling clk edge. btn_raw takes
   // raw_next mid low-phase so it is stable at the next sample_clk rise.
   task automatic run_period(input logic [N-1:0] raw_next, input bit do_reset);
      logic [N-1:0] lvl_old;
      period_no++;
      lvl_old    = m_level;
      sample_clk = 1'b1;
      model_tick(btn_raw);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 5) sample_clk = 1'b0;
         if (c == 7) btn_raw = raw_next;
         if (do_reset && c == 6) begin
            reset_n = 1'b0;
            #1;
            model_reset();
            lvl_old = '0;
         end
         if (do_reset && c == 8) reset_n = 1'b1;
         check($sformatf("level c%0d", c), btn_level, (c >= 3 && !(do_reset && c >= 6)) ? m_level : lvl_old);
         check($sformatf("press c%0d", c), btn_press, (c == 3) ? m_press : '0);
         check($sformatf("release c%0d", c), btn_release, (c == 3) ? m_rel : '0);
      end
   endtask

   initial begin
      model_reset();
      // Reset with every button held down (active-low raw 0).
      repeat (3) @(negedge clk);
      check("reset level", btn_level, '0);
      check("reset press", btn_press, '0);
      check("reset release", btn_release, '0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Held buttons accepted on the 4th tick after reset.
      repeat (5) run_period(4'b0000, 1'b0);
      // Release everything.
      repeat (6) run_period(4'b1111, 1'b0);
      // Clean press on ch0, then held.
      repeat (7) run_period(4'b1110, 1'b0);
      repeat (6) run_period(4'b1111, 1'b0);
      // Bounce on ch0 before settling pressed.
      run_period(4'b1110, 1'b0);
      run_period(4'b1111, 1'b0);
      run_period(4'b1110, 1'b0);
      run_period(4'b1111, 1'b0);
      repeat (6) run_period(4'b1110, 1'b0);
      // Release ch0.
      repeat (6) run_period(4'b1111, 1'b0);
      // Simultaneous press on ch1 and ch3.
      repeat (6) run_period(4'b0101, 1'b0);
      repeat (6) run_period(4'b1111, 1'b0);
      // Reset after the second tick of a ch2 press.
      run_period(4'b1011, 1'b0);
      run_period(4'b1011, 1'b0);
      run_period(4'b1011, 1'b1);
      repeat (6) run_period(4'b1011, 1'b0);

      // Random bouncing on all channels with occasional resets.
      for (int i = 0; i < 80; i++) begin
         logic [N-1:0] mask;
         for (int b = 0; b < N; b++) mask[b] = ($urandom_range(0, 3) == 0);
         run_period(btn_raw ^ mask, ($urandom_range(0, 29) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
